tcm_loader: RTL and testbench

- Boot-time program loader sitting directly upstream of port #2 of the dual-port TCM scratchpad.
- Consumes a length-prefixed byte stream (e.g. from a UART receiver) and packs payload bytes little-endian into DATA_WIDTH-bit words.
- Issues single-cycle byte-enabled writes into consecutive TCM entries starting at BASE_ENTRY.
- Reports completion, error and a running byte checksum to the boot controller.

---
 rtl/tcm_loader.sv | 182 ++++++++++++++++++
 tb/tb_tcm_loader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/tcm_loader.sv
// tcm_loader: boot-time loader that turns a length-prefixed byte stream into
// byte-enabled word writes on one port of the TCM scratchpad.
//
// Byte stream handshake: a byte moves on a rising clk edge when s_valid_i and
// s_ready_o are both high. The producer must hold s_data_i stable while
// s_valid_i is high and s_ready_o is low. s_ready_o never depends on
// s_valid_i.
module tcm_loader #(
   parameter int DATA_WIDTH = 32,
   parameter int N_ENTRIES  = 1024,
   parameter int BASE_ENTRY = 0
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         start_i,
   input  logic                         s_valid_i,
   input  logic [7:0]                   s_data_i,
   output logic                         s_ready_o,
   output logic                         en_o,
   output logic                         we_o,
   output logic [DATA_WIDTH/8-1:0]      be_o,
   output logic [$clog2(N_ENTRIES)-1:0] addr_o,
   output logic [DATA_WIDTH-1:0]        data_o,
   output logic                         busy_o,
   output logic                         done_o,
   output logic                         err_o,
   output logic [31:0]                  sum_o
);

   localparam int NB = DATA_WIDTH / 8;
   localparam int AW = $clog2(N_ENTRIES);
   localparam int LW = (NB > 1) ? $clog2(NB) : 1;
   // Largest payload that fits between BASE_ENTRY and the top of the TCM.
   // Held in 33 bits so a 32-bit LEN can be compared without overflow.
   localparam logic [32:0] MAX_BYTES = 33'((N_ENTRIES - BASE_ENTRY) * NB);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HDR   = 3'd1,
      S_DATA  = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4,
      S_ERR   = 3'd5
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic [31:0]     len_q;
   logic [1:0]      hdr_cnt_q;
   logic [31:0]     byte_cnt_q;
   logic [LW-1:0]   lane_q;
   logic [DATA_WIDTH-1:0] buf_q;
   logic [NB-1:0]   be_q;
   logic [AW-1:0]   ptr_q;
   logic [31:0]     sum_q;
   logic            done_q;

   logic            accept;
   logic            start_ok;
   logic            last_lane;
   logic [31:0]     len_full;
   logic [31:0]     byte_cnt_inc;

   assign accept       = s_valid_i && s_ready_o;
   assign start_ok     = start_i && ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
   assign last_lane    = (lane_q == LW'(NB - 1));
   // LEN as it will read once the byte being accepted is shifted in at the top.
   assign len_full     = {s_data_i, len_q[31:8]};
   assign byte_cnt_inc = byte_cnt_q + 32'd1;

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state decode and state-derived outputs.
   always_comb begin
      state_d   = state_q;
      s_ready_o = 1'b0;
      en_o      = 1'b0;
      we_o      = 1'b0;
      busy_o    = 1'b0;
      err_o     = 1'b0;
      be_o      = '0;
      addr_o    = '0;
      data_o    = '0;
      case (state_q)
         S_IDLE: begin
            if (start_i) state_d = S_HDR;
         end
         S_HDR: begin
            s_ready_o = 1'b1;
            busy_o    = 1'b1;
            if (accept && (hdr_cnt_q == 2'd3)) begin
               if (len_full == 32'd0)                 state_d = S_DONE;
               else if ({1'b0, len_full} > MAX_BYTES) state_d = S_ERR;
               else                                   state_d = S_DATA;
            end
         end
         S_DATA: begin
            s_ready_o = 1'b1;
            busy_o    = 1'b1;
            if (accept && (last_lane || (byte_cnt_inc == len_q))) state_d = S_WRITE;
         end
         S_WRITE: begin
            en_o    = 1'b1;
            we_o    = 1'b1;
            busy_o  = 1'b1;
            be_o    = be_q;
            addr_o  = ptr_q;
            data_o  = buf_q;
            state_d = (byte_cnt_q == len_q) ? S_DONE : S_DATA;
         end
         S_DONE: begin
            if (start_i) state_d = S_HDR;
         end
         S_ERR: begin
            err_o = 1'b1;
            if (start_i) state_d = S_HDR;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign done_o = done_q;
   assign sum_o  = sum_q;

   // Header capture, word packing, write pointer, checksum and done pulse.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         len_q      <= '0;
         hdr_cnt_q  <= '0;
         byte_cnt_q <= '0;
         lane_q     <= '0;
         buf_q      <= '0;
         be_q       <= '0;
         ptr_q      <= '0;
         sum_q      <= '0;
         done_q     <= 1'b0;
      end else begin
         // High only in the first cycle spent in DONE.
         done_q <= (state_d == S_DONE) && (state_q != S_DONE);
         if (start_ok) begin
            len_q      <= '0;
            hdr_cnt_q  <= '0;
            byte_cnt_q <= '0;
            lane_q     <= '0;
            buf_q      <= '0;
            be_q       <= '0;
            ptr_q      <= AW'(BASE_ENTRY);
            sum_q      <= '0;
         end else begin
            case (state_q)
               S_HDR: begin
                  if (accept) begin
                     len_q     <= len_full;
                     hdr_cnt_q <= hdr_cnt_q + 2'd1;
                  end
               end
               S_DATA: begin
                  if (accept) begin
                     buf_q[int'(lane_q) * 8 +: 8] <= s_data_i;
                     be_q[lane_q]                 <= 1'b1;
                     sum_q                        <= sum_q + {24'd0, s_data_i};
                     byte_cnt_q                   <= byte_cnt_inc;
                     lane_q                       <= lane_q + LW'(1);
                  end
               end
               S_WRITE: begin
                  buf_q  <= '0;
                  be_q   <= '0;
                  lane_q <= '0;
                  ptr_q  <= ptr_q + AW'(1);
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tcm_loader.sv
// tb_tcm_loader: directed test of tcm_loader. Two instances (BASE_ENTRY 0 and
// 16) receive the same stream; each write is matched against an expected
// queue by a per-instance monitor.
module tb_tcm_loader;

   localparam int AW = 10;
   localparam int EW = AW + 32 + 4;

   logic clk;
   logic rst;
   logic start;
   logic s_valid;
   logic [7:0] s_data;

   logic ready0, en0, we0, busy0, done0, err0;
   logic [3:0] be0;
   logic [AW-1:0] addr0;
   logic [31:0] data0, sum0;
   logic ready1, en1, we1, busy1, done1, err1;
   logic [3:0] be1;
   logic [AW-1:0] addr1;
   logic [31:0] data1, sum1;

   logic [EW-1:0] exp0_q[$];
   logic [EW-1:0] exp1_q[$];
   logic [EW-1:0] e0, e1;

   int n_vec = 0;
   int n_err = 0;

   tcm_loader #(.DATA_WIDTH(32), .N_ENTRIES(1024), .BASE_ENTRY(0)) dut0 (
      .clk_i(clk), .rst_i(rst), .start_i(start), .s_valid_i(s_valid), .s_data_i(s_data),
      .s_ready_o(ready0), .en_o(en0), .we_o(we0), .be_o(be0), .addr_o(addr0),
      .data_o(data0), .busy_o(busy0), .done_o(done0), .err_o(err0), .sum_o(sum0)
   );

   tcm_loader #(.DATA_WIDTH(32), .N_ENTRIES(1024), .BASE_ENTRY(16)) dut1 (
      .clk_i(clk), .rst_i(rst), .start_i(start), .s_valid_i(s_valid), .s_data_i(s_data),
      .s_ready_o(ready1), .en_o(en1), .we_o(we1), .be_o(be1), .addr_o(addr1),
      .data_o(data1), .busy_o(busy1), .done_o(done1), .err_o(err1), .sum_o(sum1)
   );

   // Clock and watchdog.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic exp_write(input int idx, input logic [31:0] d, input logic [3:0] be);
      exp0_q.push_back({AW'(idx), d, be});
      exp1_q.push_back({AW'(idx + 16), d, be});
   endtask

   // Monitors: every TCM write must match the head of the expected queue.
   always @(negedge clk) begin
      if (en0 || we0) begin
         if (exp0_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL write0: unexpected write addr 0x%0h data 0x%0h be 0x%0h", addr0, data0, be0);
         end else begin
            e0 = exp0_q.pop_front();
            check("write0", 64'({addr0, data0, be0, en0, we0}), 64'({e0, 2'b11}));
         end
      end
   end

   always @(negedge clk) begin
      if (en1 || we1) begin
         if (exp1_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL write1: unexpected write addr 0x%0h data 0x%0h be 0x%0h", addr1, data1, be1);
         end else begin
            e1 = exp1_q.pop_front();
            check("write1", 64'({addr1, data1, be1, en1, we1}), 64'({e1, 2'b11}));
         end
      end
   end

   // Driver tasks; all drive happens 1 time unit after a rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      t = 0;
      s_valid = 1'b1;
      s_data  = b;
      while (!ready0 && t < 100) begin
         tick();
         t++;
      end
      if (t >= 100) begin
         n_vec++;
         n_err++;
         $display("FAIL send_byte: byte 0x%0h not accepted within 100 cycles", b);
      end
      tick();
      s_valid = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic send_len(input logic [31:0] l, input int gap);
      for (int i = 0; i < 4; i++) send_byte(l[8*i +: 8], gap);
   endtask

   task automatic wait_done(input string name, input logic [31:0] exp_sum);
      int t;
      t = 0;
      while (!done0 && t < 60) begin
         tick();
         t++;
      end
      check({name, "_done0"}, 64'(done0), 64'd1);
      check({name, "_done1"}, 64'(done1), 64'd1);
      check({name, "_sum0"}, 64'(sum0), 64'(exp_sum));
      check({name, "_sum1"}, 64'(sum1), 64'(exp_sum));
      tick();
      check({name, "_done_pulse"}, 64'({done0, done1}), 64'd0);
      check({name, "_sum_hold"}, 64'(sum0), 64'(exp_sum));
   endtask

   logic [7:0] pay1 [8];
   logic [7:0] pay2 [5];

   initial begin
      pay1 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      pay2 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
      rst = 1'b1;
      start = 1'b0;
      s_valid = 1'b0;
      s_data = 8'h00;
      repeat (3) tick();
      check("reset_ctrl", 64'({ready0, en0, we0, busy0, done0, err0}), 64'd0);
      check("reset_data", 64'({be0, addr0, data0, sum0}), 64'd0);
      check("reset_ctrl1", 64'({ready1, en1, we1, busy1, done1, err1}), 64'd0);
      rst = 1'b0;
      tick();
      check("idle_ready", 64'({ready0, busy0}), 64'd0);

      // Two full words.
      pulse_start();
      check("hdr_busy", 64'({ready0, busy0}), 64'b11);
      exp_write(0, 32'h44332211, 4'hF);
      exp_write(1, 32'h88776655, 4'hF);
      send_len(32'd8, 0);
      foreach (pay1[i]) send_byte(pay1[i], 0);
      wait_done("s1", 32'h00000264);

      // Partial final word.
      pulse_start();
      exp_write(0, 32'hDDCCBBAA, 4'hF);
      exp_write(1, 32'h000000EE, 4'h1);
      send_len(32'd5, 0);
      foreach (pay2[i]) send_byte(pay2[i], 0);
      wait_done("s2", 32'h000003FC);

      // Empty load.
      pulse_start();
      send_len(32'd0, 0);
      check("len0_done_latency", 64'({done0, done1, busy0}), 64'b110);
      wait_done("s3", 32'd0);

      // Oversized load.
      pulse_start();
      send_len(32'h00001001, 0);
      check("err_level", 64'({err0, err1}), 64'b11);
      check("err_ready", 64'({ready0, ready1, busy0}), 64'd0);
      s_valid = 1'b1;
      s_data  = 8'h5A;
      repeat (3) tick();
      check("err_hold", 64'({err0, ready0}), 64'b10);
      s_valid = 1'b0;
      pulse_start();
      check("err_clear", 64'({err0, err1, busy0, ready0}), 64'b0011);

      // Same as the first load with a gappy producer and a byte held across WRITE.
      exp_write(0, 32'h44332211, 4'hF);
      exp_write(1, 32'h88776655, 4'hF);
      send_len(32'd8, 1);
      foreach (pay1[i]) send_byte(pay1[i], (i == 3) ? 0 : 1);
      wait_done("s5", 32'h00000264);

      // Reset in the middle of a load, then a fresh load.
      pulse_start();
      send_len(32'd8, 0);
      for (int i = 0; i < 3; i++) send_byte(pay1[i], 0);
      rst = 1'b1;
      tick();
      check("midrst_ctrl", 64'({ready0, busy0, done0, err0, en0}), 64'd0);
      check("midrst_sum", 64'(sum0), 64'd0);
      rst = 1'b0;
      tick();
      pulse_start();
      exp_write(0, 32'h04030201, 4'hF);
      send_len(32'd4, 0);
      for (int i = 1; i <= 4; i++) send_byte(8'(i), 0);
      wait_done("s6", 32'h0000000A);

      repeat (5) tick();
      check("exp0_drained", 64'(exp0_q.size()), 64'd0);
      check("exp1_drained", 64'(exp1_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
